// File: rtl/fetch_realign_buffer_pkg.sv
// fetch_realign_buffer_pkg
//   Shared constants and types for the fetch realignment buffer.
//   - OPC_LOW_32 : low two opcode bits that mark a 32-bit instruction
//   - WADDR_W    : instruction-cache word-address width
//   - NOP        : canonical 32-bit NOP (addi x0, x0, 0), kept with the IF-stage constants
//   - fsm_state_t: refill controller states
package fetch_realign_buffer_pkg;

  localparam int          WADDR_W    = 30;
  localparam logic [1:0]  OPC_LOW_32 = 2'b11;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } fsm_state_t;

  // A halfword whose low two bits are 2'b11 starts a 32-bit instruction.
  function automatic logic is_full_width(input logic [15:0] half);
    return half[1:0] == OPC_LOW_32;
  endfunction

endpackage

// File: rtl/fetch_realign_buffer_entries.sv
// realign_buf_entries
//   Two-entry tag/data word buffer with two simultaneous lookups, victim
//   selection and a single lru bit.
//   Ports:
//     clk, rst            : clock, asynchronous active-high reset
//     i_tag_a / i_tag_b   : word addresses looked up this cycle (wa / wa+1)
//     o_hit_a / o_data_a  : lookup result for i_tag_a
//     o_hit_b / o_data_b  : lookup result for i_tag_b
//     i_fill_en           : write i_fill_tag/i_fill_data into the victim at the edge
module realign_buf_entries #(
  parameter int TAG_W  = 30,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TAG_W-1:0]  i_tag_a,
  input  logic [TAG_W-1:0]  i_tag_b,
  input  logic              i_fill_en,
  input  logic [TAG_W-1:0]  i_fill_tag,
  input  logic [DATA_W-1:0] i_fill_data,
  output logic              o_hit_a,
  output logic [DATA_W-1:0] o_data_a,
  output logic              o_hit_b,
  output logic [DATA_W-1:0] o_data_b
);

  logic [1:0]        r_valid;
  logic [TAG_W-1:0]  r_tag  [2];
  logic [DATA_W-1:0] r_data [2];
  logic              r_lru;

  logic [1:0] w_match_a;
  logic [1:0] w_match_b;
  logic       w_victim;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_match_a[i] = r_valid[i] & (r_tag[i] == i_tag_a);
      w_match_b[i] = r_valid[i] & (r_tag[i] == i_tag_b);
    end
  end

  assign o_hit_a  = |w_match_a;
  assign o_hit_b  = |w_match_b;
  assign o_data_a = w_match_a[1] ? r_data[1] : (w_match_a[0] ? r_data[0] : '0);
  assign o_data_b = w_match_b[1] ? r_data[1] : (w_match_b[0] ? r_data[0] : '0);

  // Never evict the word the current PC sits in; this protects the first
  // half of a straddling instruction while its second word is fetched.
  assign w_victim = w_match_a[0] ? 1'b1 :
                    w_match_a[1] ? 1'b0 : r_lru;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 2'b00;
      r_lru   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
    end else if (i_fill_en) begin
      r_valid[w_victim] <= 1'b1;
      r_tag[w_victim]   <= i_fill_tag;
      r_data[w_victim]  <= i_fill_data;
      r_lru             <= ~w_victim;
    end
  end

endmodule

// File: rtl/fetch_realign_buffer.sv
// fetch_realign_buffer
//   Realigns halfword-aligned fetches into whole instructions, using a
//   two-word buffer in front of a read-only instruction cache.
//   Ports:
//     clk, rst         : clock, asynchronous active-high reset
//     pc               : IF-stage PC (pc[0] is always 0)
//     ready            : inst/compressed valid this cycle
//     compressed       : 16-bit instruction at pc
//     inst             : realigned instruction (upper half zero when compressed)
//     ICACHE_*         : cache read port; wen/wdata tied off
//
//   state | meaning
//   IDLE  | serve from buffer; on a miss request the missing word
//   WAIT  | cache stalled; hold request on the latched word address
module fetch_realign_buffer #(
  parameter int XLEN    = 32,
  parameter int WADDR_W = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [XLEN-1:0]    pc,
  output logic               ready,
  output logic               compressed,
  output logic [XLEN-1:0]    inst,
  input  logic               ICACHE_stall,
  output logic               ICACHE_ren,
  output logic               ICACHE_wen,
  output logic [WADDR_W-1:0] ICACHE_addr,
  input  logic [XLEN-1:0]    ICACHE_rdata,
  output logic [XLEN-1:0]    ICACHE_wdata
);

  import fetch_realign_buffer_pkg::*;

  fsm_state_t         r_state;
  fsm_state_t         w_state_nxt;
  logic [WADDR_W-1:0] r_pend_addr;

  logic [WADDR_W-1:0] w_wa;
  logic [WADDR_W-1:0] w_wb;
  logic               w_hit_a;
  logic               w_hit_b;
  logic [XLEN-1:0]    w_data_a;
  logic [XLEN-1:0]    w_data_b;
  logic [15:0]        w_half;
  logic               w_need_b;
  logic               w_miss;
  logic [WADDR_W-1:0] w_miss_addr;
  logic               w_fill_en;
  logic               w_pend_load;
  logic               w_unused_pc0;

  assign w_unused_pc0 = pc[0];

  assign w_wa = pc[XLEN-1:2];
  assign w_wb = w_wa + {{(WADDR_W-1){1'b0}}, 1'b1};

  realign_buf_entries #(
    .TAG_W  (WADDR_W),
    .DATA_W (XLEN)
  ) u_entries (
    .clk         (clk),
    .rst         (rst),
    .i_tag_a     (w_wa),
    .i_tag_b     (w_wb),
    .i_fill_en   (w_fill_en),
    .i_fill_tag  (ICACHE_addr),
    .i_fill_data (ICACHE_rdata),
    .o_hit_a     (w_hit_a),
    .o_data_a    (w_data_a),
    .o_hit_b     (w_hit_b),
    .o_data_b    (w_data_b)
  );

  assign w_half   = pc[1] ? w_data_a[31:16] : w_data_a[15:0];
  // w_data_a is zero on a wa miss, so need_b only matters once wa hits.
  assign w_need_b = pc[1] & is_full_width(w_half);
  assign w_miss   = ~w_hit_a | (w_need_b & ~w_hit_b);
  assign w_miss_addr = ~w_hit_a ? w_wa : w_wb;

  // Output mux: buffer contents only, never forwarded from rdata.
  always_comb begin
    ready      = w_hit_a & (~w_need_b | w_hit_b) & (r_state == ST_IDLE) & ~rst;
    compressed = ready & ~is_full_width(w_half);
    inst       = '0;
    if (ready) begin
      if (compressed)    inst = {{(XLEN-16){1'b0}}, w_half};
      else if (w_need_b) inst = {w_data_b[15:0], w_data_a[31:16]};
      else               inst = w_data_a;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_miss && ICACHE_stall) w_state_nxt = ST_WAIT;
      ST_WAIT: if (!ICACHE_stall)          w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Reset forces the request low combinationally so an abandoned WAIT
  // never leaves ren asserted, even before any clock edge.
  always_comb begin
    ICACHE_ren  = 1'b0;
    ICACHE_addr = '0;
    w_pend_load = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_IDLE: begin
          if (w_miss) begin
            ICACHE_ren  = 1'b1;
            ICACHE_addr = w_miss_addr;
            w_pend_load = ICACHE_stall;
          end
        end
        ST_WAIT: begin
          ICACHE_ren  = 1'b1;
          ICACHE_addr = r_pend_addr;
        end
        default: ;
      endcase
    end
    w_fill_en = ICACHE_ren & ~ICACHE_stall;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_pend_addr <= '0;
    else if (w_pend_load) r_pend_addr <= ICACHE_addr;
  end

  assign ICACHE_wen   = 1'b0;
  assign ICACHE_wdata = '0;

endmodule

// File: tb/tb_fetch_realign_buffer.sv
module tb_fetch_realign_buffer;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        ready;
  logic        compressed;
  logic [31:0] inst;
  logic        ICACHE_stall;
  logic        ICACHE_ren;
  logic        ICACHE_wen;
  logic [29:0] ICACHE_addr;
  logic [31:0] ICACHE_rdata;
  logic [31:0] ICACHE_wdata;

  fetch_realign_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .ready        (ready),
    .compressed   (compressed),
    .inst         (inst),
    .ICACHE_stall (ICACHE_stall),
    .ICACHE_ren   (ICACHE_ren),
    .ICACHE_wen   (ICACHE_wen),
    .ICACHE_addr  (ICACHE_addr),
    .ICACHE_rdata (ICACHE_rdata),
    .ICACHE_wdata (ICACHE_wdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // obs/exp layout: {ready, compressed, ren, addr[29:0], inst[31:0]}
  logic [64:0] obs;
  logic [64:0] exp_v;

  logic [31:0] mem [bit [29:0]];

  function automatic logic [31:0] mem_rd(input logic [29:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'hD00D_0000 ^ {2'b00, a};
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cache model: data for the presented address, settled well before the edge.
  always @(negedge clk) ICACHE_rdata = mem_rd(ICACHE_addr);

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, failures so far %0d", n_fail);
    $fatal(1, "timeout");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ICACHE_stall = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; pc = 32'h0000_0100; ICACHE_stall = 1'b1;
    #1;
    obs = {ready, compressed, ICACHE_ren, ICACHE_addr, inst};
    n_checks++;
    if (obs !== 65'h0) begin
      $display("FAIL reset_outputs: got %h want %h", obs, 65'h0); n_fail++;
    end
    n_checks++;
    if ({ICACHE_wen, ICACHE_wdata} !== 33'h0) begin
      $display("FAIL reset_tieoffs: got %h want 0", {ICACHE_wen, ICACHE_wdata}); n_fail++;
    end
    @(negedge clk);
    obs = {ready, compressed, ICACHE_ren, ICACHE_addr, inst};
    n_checks++;
    if (obs !== 65'h0) begin
      $display("FAIL reset_clocked: got %h want %h", obs, 65'h0); n_fail++;
    end
    next_cycle();
    ICACHE_stall = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_cold_fetch();
    mem[30'h0] = 32'h0050_0093;
    do_reset();
    pc = 32'h0;
    @(negedge clk);
    obs = {ready, compressed, ICACHE_ren, ICACHE_addr, inst};
    exp_v = {1'b0, 1'b0, 1'b1, 30'h0, 32'h0};
    n_checks++;
    if (obs !== exp_v) begin $display("FAIL cold_request: got %h want %h", obs, exp_v); n_fail++; end
    next_cycle();
    @(negedge clk);
    obs = {ready, compressed, ICACHE_ren, ICACHE_addr, inst};
    exp_v = {1'b1, 1'b0, 1'b0, 30'h0, 32'h0050_0093};
    n_checks++;
    if (obs !== exp_v) begin $display("FAIL cold_ready: got %h want %h", obs, exp_v); n_fail++; end
    next_cycle();
  endtask

  task automatic test_compressed_pair();
    mem[30'h0] = 32'h4505_0001;
    do_reset();
    pc = 32'h0;
    next_cycle();
    @(negedge clk);
    obs = {ready, compressed, ICACHE_ren, ICACHE_addr, inst};
    exp_v = {1'b1, 1'b1, 1'b0, 30'h0, 32'h0000_0001};
    n_checks++;
    if (obs !== exp_v) begin $display("FAIL compressed_lo: got %h want %h", obs, exp_v); n_fail++; end
    next_cycle();
    pc = 32'h2;
    @(negedge clk);
    obs = {ready, compressed, ICACHE_ren, ICACHE_addr, inst};
    exp_v = {1'b1, 1'b1, 1'b0, 30'h0, 32'h0000_4505};
    n_checks++;
    if (obs !== exp_v) begin $display("FAIL compressed_hi: got %h want %h", obs, exp_v); n_fail++; end
    next_cycle();
  endtask

  task automatic test_straddle();
    mem[30'h1] = 32'h0093_0000;
    mem[30'h2] = 32'h1111_0050;
    do_reset();
    pc = 32'h4;
    next_cycle();
    @(negedge clk);
    obs = {ready, compressed, ICACHE_ren, ICACHE_addr, inst};
    exp_v = {1'b1, 1'b1, 1'b0, 30'h0, 32'h0};
    n_checks++;
    if (obs !== exp_v) begin $display("FAIL straddle_word1: got %h want %h", obs, exp_v); n_fail++; end
    next_cycle();
    pc = 32'h6;
    @(negedge clk);
    obs = {ready, compressed, ICACHE_ren, ICACHE_addr, inst};
    exp_v = {1'b0, 1'b0, 1'b1, 30'h2, 32'h0};
    n_checks++;
    if (obs !== exp_v) begin $display("FAIL straddle_req: got %h want %h", obs, exp_v); n_fail++; end
    next_cycle();
    @(negedge clk);
    obs = {ready, compressed, ICACHE_ren, ICACHE_addr, inst};
    exp_v = {1'b1, 1'b0, 1'b0, 30'h0, 32'h0050_0093};
    n_checks++;
    if (obs !== exp_v) begin $display("FAIL straddle_ready: got %h want %h", obs, exp_v); n_fail++; end
    next_cycle();
    pc = 32'hA;
    @(negedge clk);
    obs = {ready, compressed, ICACHE_ren, ICACHE_addr, inst};
    exp_v = {1'b1, 1'b1, 1'b0, 30'h0, 32'h0000_1111};
    n_checks++;
    if (obs !== exp_v) begin $display("FAIL straddle_hit_a: got %h want %h", obs, exp_v); n_fail++; end
    next_cycle();
  endtask

  task automatic test_stalled_miss();
    mem[30'h40] = 32'h1234_5677;
    mem[30'h80] = 32'h00A0_0113;
    do_reset();
    pc = 32'h100;
    ICACHE_stall = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) pc = 32'h200;
      if (c == 3) ICACHE_stall = 1'b0;
      @(negedge clk);
      obs = {ready, compressed, ICACHE_ren, ICACHE_addr, inst};
      exp_v = {1'b0, 1'b0, 1'b1, 30'h40, 32'h0};
      n_checks++;
      if (obs !== exp_v) begin
        $display("FAIL stall_hold_c%0d: got %h want %h", c, obs, exp_v); n_fail++;
      end
      next_cycle();
    end
    @(negedge clk);
    obs = {ready, compressed, ICACHE_ren, ICACHE_addr, inst};
    exp_v = {1'b0, 1'b0, 1'b1, 30'h80, 32'h0};
    n_checks++;
    if (obs !== exp_v) begin $display("FAIL stall_second_req: got %h want %h", obs, exp_v); n_fail++; end
    next_cycle();
    @(negedge clk);
    obs = {ready, compressed, ICACHE_ren, ICACHE_addr, inst};
    exp_v = {1'b1, 1'b0, 1'b0, 30'h0, 32'h00A0_0113};
    n_checks++;
    if (obs !== exp_v) begin $display("FAIL stall_ready: got %h want %h", obs, exp_v); n_fail++; end
    next_cycle();
    pc = 32'h100;
    @(negedge clk);
    obs = {ready, compressed, ICACHE_ren, ICACHE_addr, inst};
    exp_v = {1'b1, 1'b0, 1'b0, 30'h0, 32'h1234_5677};
    n_checks++;
    if (obs !== exp_v) begin $display("FAIL stall_kept_word: got %h want %h", obs, exp_v); n_fail++; end
    next_cycle();
  endtask

  task automatic test_wrap();
    mem[30'h3FFF_FFFF] = 32'h4B83_1234;
    mem[30'h0]         = 32'h9ABC_7F00;
    do_reset();
    pc = 32'hFFFF_FFFE;
    @(negedge clk);
    obs = {ready, compressed, ICACHE_ren, ICACHE_addr, inst};
    exp_v = {1'b0, 1'b0, 1'b1, 30'h3FFF_FFFF, 32'h0};
    n_checks++;
    if (obs !== exp_v) begin $display("FAIL wrap_req_a: got %h want %h", obs, exp_v); n_fail++; end
    next_cycle();
    @(negedge clk);
    obs = {ready, compressed, ICACHE_ren, ICACHE_addr, inst};
    exp_v = {1'b0, 1'b0, 1'b1, 30'h0, 32'h0};
    n_checks++;
    if (obs !== exp_v) begin $display("FAIL wrap_req_b: got %h want %h", obs, exp_v); n_fail++; end
    next_cycle();
    @(negedge clk);
    obs = {ready, compressed, ICACHE_ren, ICACHE_addr, inst};
    exp_v = {1'b1, 1'b0, 1'b0, 30'h0, 32'h7F00_4B83};
    n_checks++;
    if (obs !== exp_v) begin $display("FAIL wrap_ready: got %h want %h", obs, exp_v); n_fail++; end
    next_cycle();
  endtask

  task automatic test_async_reset();
    mem[30'h0] = 32'h0000_0013;
    do_reset();
    pc = 32'h0;
    next_cycle();
    @(negedge clk);
    obs = {ready, compressed, ICACHE_ren, ICACHE_addr, inst};
    exp_v = {1'b1, 1'b0, 1'b0, 30'h0, 32'h0000_0013};
    n_checks++;
    if (obs !== exp_v) begin $display("FAIL areset_prefill: got %h want %h", obs, exp_v); n_fail++; end
    next_cycle();
    pc = 32'h300;
    ICACHE_stall = 1'b1;
    next_cycle();
    @(negedge clk);
    obs = {ready, compressed, ICACHE_ren, ICACHE_addr, inst};
    exp_v = {1'b0, 1'b0, 1'b1, 30'hC0, 32'h0};
    n_checks++;
    if (obs !== exp_v) begin $display("FAIL areset_in_wait: got %h want %h", obs, exp_v); n_fail++; end
    #2;
    rst = 1'b1;
    #1;
    obs = {ready, compressed, ICACHE_ren, ICACHE_addr, inst};
    n_checks++;
    if (obs !== 65'h0) begin $display("FAIL areset_immediate: got %h want %h", obs, 65'h0); n_fail++; end
    next_cycle();
    rst = 1'b0;
    ICACHE_stall = 1'b0;
    pc = 32'h0;
    @(negedge clk);
    obs = {ready, compressed, ICACHE_ren, ICACHE_addr, inst};
    exp_v = {1'b0, 1'b0, 1'b1, 30'h0, 32'h0};
    n_checks++;
    if (obs !== exp_v) begin $display("FAIL areset_refetch: got %h want %h", obs, exp_v); n_fail++; end
    next_cycle();
    @(negedge clk);
    obs = {ready, compressed, ICACHE_ren, ICACHE_addr, inst};
    exp_v = {1'b1, 1'b0, 1'b0, 30'h0, 32'h0000_0013};
    n_checks++;
    if (obs !== exp_v) begin $display("FAIL areset_ready: got %h want %h", obs, exp_v); n_fail++; end
    next_cycle();
  endtask

  // Reference: buffer as two slots of (tag, data); expected instruction is
  // the little-endian instruction stream read at pc out of the buffered words.
  task automatic test_random();
    logic        m_valid [2];
    logic [29:0] m_tag   [2];
    logic [31:0] m_data  [2];
    int          m_lru;
    bit          m_wait;
    logic [29:0] m_pend;
    logic [29:0] wa, wb;
    logic [31:0] a_w, b_w;
    logic [15:0] half;
    logic [63:0] stream;
    logic [31:0] e_inst;
    logic [29:0] e_addr;
    bit          e_ready, e_comp, e_ren, nb;
    int          ia, ib, victim, idx;

    for (int i = 0; i < 5; i++) mem[30'(i)] = $urandom;
    mem[30'h3FFF_FFFF] = $urandom;
    for (int i = 0; i < 2; i++) begin m_valid[i] = 0; m_tag[i] = '0; m_data[i] = '0; end
    m_lru = 0; m_wait = 0; m_pend = '0;
    do_reset();
    pc = 32'h0;

    for (int cyc = 0; cyc < 500; cyc++) begin
      if ($urandom_range(0, 1) == 1) begin
        idx = $urandom_range(0, 5);
        wa = (idx == 5) ? 30'h3FFF_FFFF : 30'(idx);
        pc = {wa, 1'($urandom_range(0, 1)), 1'b0};
      end
      ICACHE_stall = ($urandom_range(0, 3) == 0);
      @(negedge clk);

      wa = pc[31:2];
      wb = wa + 30'd1;
      ia = -1; ib = -1;
      for (int i = 0; i < 2; i++) begin
        if (m_valid[i] && m_tag[i] == wa) ia = i;
        if (m_valid[i] && m_tag[i] == wb) ib = i;
      end
      e_ready = 0; e_comp = 0; e_ren = 0; e_addr = '0; e_inst = '0;
      if (m_wait) begin
        e_ren = 1; e_addr = m_pend;
      end else if (ia < 0) begin
        e_ren = 1; e_addr = wa;
      end else begin
        a_w  = m_data[ia];
        b_w  = (ib >= 0) ? m_data[ib] : 32'h0;
        half = pc[1] ? a_w[31:16] : a_w[15:0];
        nb   = pc[1] && (half[1:0] == 2'b11);
        if (nb && ib < 0) begin
          e_ren = 1; e_addr = wb;
        end else begin
          e_ready = 1;
          stream  = {b_w, a_w} >> (pc[1] ? 16 : 0);
          e_comp  = (stream[1:0] != 2'b11);
          e_inst  = e_comp ? {16'h0, stream[15:0]} : stream[31:0];
        end
      end

      obs = {ready, compressed, ICACHE_ren, ICACHE_addr, inst};
      exp_v = {e_ready, e_comp, e_ren, e_addr, e_inst};
      n_checks++;
      if (obs !== exp_v) begin
        $display("FAIL random_c%0d pc=%h stall=%0d: got %h want %h", cyc, pc, ICACHE_stall, obs, exp_v);
        n_fail++;
      end

      if (e_ren && !ICACHE_stall) begin
        victim = (ia >= 0) ? 1 - ia : m_lru;
        m_valid[victim] = 1;
        m_tag[victim]   = e_addr;
        m_data[victim]  = mem_rd(e_addr);
        m_lru  = 1 - victim;
        m_wait = 0;
      end else if (e_ren && !m_wait) begin
        m_wait = 1;
        m_pend = e_addr;
      end
      next_cycle();
    end
    ICACHE_stall = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    pc = 32'h0;
    ICACHE_stall = 1'b0;
    ICACHE_rdata = 32'h0;
    #2;
    test_reset();
    test_cold_fetch();
    test_compressed_pair();
    test_straddle();
    test_stalled_miss();
    test_wrap();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_realign_buffer.md
Name: fetch_realign_buffer

Overview:
- Sits between the instruction cache and the IF stage.
- Takes the IF-stage PC (halfword aligned) and returns one 32-bit-aligned instruction word plus a compressed flag.
- Handles 16-bit instructions and 32-bit instructions that straddle a word boundary, using a 2-entry word buffer.
- Issues ICACHE reads only on buffer misses; the cache interface is read-only.

Parameters:
- XLEN, 32, instruction/PC width.
- WADDR_W, 30, ICACHE word-address width (XLEN-2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc  in  32  IF-stage PC; pc[0] is always 0.
- ready  out  1  inst/compressed are valid this cycle.
- compressed  out  1  1 = 16-bit instruction (pc-half[1:0] != 2'b11).
- inst  out  32  aligned instruction; upper 16 bits are 0 when compressed.
- ICACHE_stall  in  1  cache busy; read not completed this cycle.
- ICACHE_ren  out  1  read request.
- ICACHE_wen  out  1  tied 0.
- ICACHE_addr  out  30  word address.
- ICACHE_rdata  in  32  read data, valid in the cycle ren=1 and ICACHE_stall=0.
- ICACHE_wdata  out  32  tied 0.

Behaviour:
- Reset is asynchronous and active-high. While rst=1:
  - both entries invalid, lru=0, state=IDLE;
  - ready=0, ICACHE_ren=0, inst=0, compressed=0, ICACHE_addr=0.
- Buffer: 2 entries, each {valid, tag[29:0], data[31:0]}. A lookup hits if either valid entry's tag matches.
- Word selection:
  - wa = pc[31:2]; wb = wa+1, modulo 2^30 (wraps 0x3FFFFFFF -> 0).
  - half = pc[1] ? A[31:16] : A[15:0], where A is the wa word.
  - need_b = pc[1] & (half[1:0]==2'b11).
- Output, combinational from the buffer only (no rdata forwarding):
  - ready = hit(wa) & (!need_b | hit(wb)) & state==IDLE.
  - compressed = ready & (half[1:0]!=2'b11).
  - inst = !ready ? 0 : compressed ? {16'h0, half} : need_b ? {B[15:0], A[31:16]} : A.
- Miss word: miss_addr = !hit(wa) ? wa : wb. A request is needed when (!hit(wa)) | (need_b & !hit(wb)); need_b is evaluated only once wa hits.
- FSM state IDLE:
  - No miss: ren=0.
  - Miss: ren=1, addr=miss_addr.
    - ICACHE_stall=0: fill a victim entry with rdata at this edge, stay IDLE.
    - ICACHE_stall=1: latch pend_addr=miss_addr, go to WAIT.
- FSM state WAIT:
  - ren=1, addr=pend_addr, held stable regardless of pc changes. ready=0.
  - On ICACHE_stall=0: fill victim with {pend_addr, rdata}, go to IDLE.
- Victim choice: the entry NOT holding wa if one does; otherwise the entry pointed to by lru. Every fill sets lru to the other entry.
- Latency: a wa miss with a non-stalling cache gives ready one cycle after the request. A straddle needing both words from cache gives ready 2 cycles after the first request. All hits give ready in the same cycle.
- pc may change in any cycle (redirect):
  - In IDLE, outputs follow the new pc immediately.
  - A WAIT still completes its fill into the buffer; the word is kept and may later hit.
- Entries are never invalidated except by reset. Reset mid-WAIT drops ren immediately and the pending request is abandoned.
- ICACHE_stall is ignored while ren=0.

Decomposition:
- Shared package: OPC_LOW_32 = 2'b11, WADDR_W, NOP constant (kept with the IF-stage constants).
- One sub-module is natural: realign_buf_entries, the 2-entry tag/data array with dual lookup, victim select and lru. FSM and mux logic stay in the top module.

Test Plan:
- Cold fetch: rst pulse, pc=0, word0=0x00500093, stall=0 -> cycle1 ren=1 addr=0; cycle2 ready=1, inst=0x00500093, compressed=0, ren=0.
- Compressed pair: word0=0x45050001 buffered -> pc=0 gives ready=1, compressed=1, inst=0x00000001; pc=2 gives inst=0x00004505; no ICACHE access.
- Straddle: word1=0x00930000, word2=0x11110050, pc=6 with word1 buffered -> ren=1 addr=2; next cycle ready=1, inst=0x00500093; then pc=0xA hits with no access.
- Stalled miss: pc=0x100, ICACHE_stall=1 for 3 cycles with pc changed to 0x200 in cycle 2 -> addr holds 0x40 with ren=1 throughout. After the fill, IDLE issues addr=0x80; ready only after the 0x80 fill.
- Wrap: pc=0xFFFFFFFE with upper half of word 0x3FFFFFFF ending in 2'b11 -> second request addr=0x0; inst={word0[15:0], word3FFFFFFF[31:16]}.
- Async reset asserted mid-WAIT -> ren=0 and ready=0 immediately, without a clock edge. After release, pc=0 refetches addr 0 (buffer cleared).
